// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and types for the register-file write path.
//   ADDR_W       register address width
//   DATA_W       register data width
//   NUM_REGS     registers cleared by the post-reset zero-fill (2**ADDR_W)
//   ctrl_state_t controller state: INIT (zero-fill) or RUN (arbitration)
package regfile_pkg;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 64;
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } ctrl_state_t;

endpackage

// File: rtl/regfile_write_ctrl_if.sv
// regfile_write_ctrl_if: writeback requesters <-> write controller <-> register
// file write port.
//   req_valid  [NUM_REQ]          per-requester write request
//   req_addr   [NUM_REQ*ADDR_W]   packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_data   [NUM_REQ*DATA_W]   packed data, requester i at [i*DATA_W +: DATA_W]
//   req_ready  [NUM_REQ]          one-hot-or-zero grant; accept = valid & ready
//   rf_write_enable/addr/data     registered register-file write port
//   init_done                     high once the zero-fill has finished
//   grant_id   [ID_W]             requester whose write is on rf_* this cycle
// master: requester side; slave: the write controller.
interface regfile_write_ctrl_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = regfile_pkg::ADDR_W,
    parameter int DATA_W  = regfile_pkg::DATA_W
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      rf_write_enable;
    logic [ADDR_W-1:0]         rf_write_addr;
    logic [DATA_W-1:0]         rf_write_data;
    logic                      init_done;
    logic [ID_W-1:0]           grant_id;

    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, rf_write_enable, rf_write_addr, rf_write_data,
               init_done, grant_id
    );

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, rf_write_enable, rf_write_addr, rf_write_data,
               init_done, grant_id
    );

endinterface

// File: rtl/regfile_write_ctrl_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
//   req     [N]      request vector
//   ptr     [IDX_W]  highest-priority index for this cycle
//   gnt     [N]      one-hot-or-zero grant
//   gnt_idx [IDX_W]  index of the granted request (0 when nothing is granted)
// The search starts at ptr and wraps modulo N; the first asserted request wins.
// The pointer itself is owned by the caller.
module rr_arbiter #(
    parameter int N = 2,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;
    logic             found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        sum     = '0;
        cand    = '0;
        for (int i = 0; i < N; i++) begin
            // One extra bit so ptr+i cannot overflow before the modulo fold.
            sum = {1'b0, ptr} + (IDX_W + 1)'(i);
            if (sum >= (IDX_W + 1)'(N)) begin
                sum = sum - (IDX_W + 1)'(N);
            end
            cand = sum[IDX_W-1:0];
            if (!found && req[cand]) begin
                found      = 1'b1;
                gnt[cand]  = 1'b1;
                gnt_idx    = cand;
            end
        end
    end

endmodule

// File: rtl/regfile_write_ctrl.sv
// regfile_write_ctrl: write-port controller for the register file.
// After reset it zero-fills every register (one per cycle), then arbitrates
// round-robin among NUM_REQ writeback requesters onto the single write port.
//   clk      clock, all state on the rising edge
//   reset_n  synchronous active-low reset; restarts the zero-fill
//   bus      regfile_write_ctrl_if.slave: request handshake in, registered
//            rf_write_* / init_done / grant_id out
module regfile_write_ctrl
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 2,
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    regfile_write_ctrl_if.slave  bus
);

    ctrl_state_t          state;
    logic [ADDR_W-1:0]    init_cnt;
    logic [ID_W-1:0]      rr_ptr;
    logic                 wr_en;
    logic [ADDR_W-1:0]    wr_addr;
    logic [DATA_W-1:0]    wr_data;
    logic [ID_W-1:0]      gid;
    logic                 done;

    logic [NUM_REQ-1:0]   gnt;
    logic [ID_W-1:0]      gnt_idx;
    logic                 accept;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req     (bus.req_valid),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Grants are withheld during the zero-fill, so requests are ignored there
    // rather than queued. The arbiter only grants valid requesters, so any
    // grant in RUN is an acceptance.
    assign bus.req_ready = (state == RUN) ? gnt : '0;
    assign accept        = (state == RUN) && (|gnt);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= INIT;
            init_cnt <= '0;
            rr_ptr   <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            gid      <= '0;
            done     <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    wr_en    <= 1'b1;
                    wr_addr  <= init_cnt;
                    wr_data  <= '0;
                    gid      <= '0;
                    init_cnt <= init_cnt + 1'b1;
                    if (init_cnt == ADDR_W'(NUM_REGS - 1)) begin
                        state <= RUN;
                        done  <= 1'b1;
                    end
                end
                RUN: begin
                    if (accept) begin
                        wr_en   <= 1'b1;
                        wr_addr <= bus.req_addr[gnt_idx*ADDR_W +: ADDR_W];
                        wr_data <= bus.req_data[gnt_idx*DATA_W +: DATA_W];
                        gid     <= gnt_idx;
                        // Winner drops to lowest priority next cycle.
                        rr_ptr  <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0
                                                                   : gnt_idx + ID_W'(1);
                    end else begin
                        // Address/data hold; only the enable drops.
                        wr_en <= 1'b0;
                    end
                end
                default: begin
                    state <= INIT;
                end
            endcase
        end
    end

    assign bus.rf_write_enable = wr_en;
    assign bus.rf_write_addr   = wr_addr;
    assign bus.rf_write_data   = wr_data;
    assign bus.grant_id        = gid;
    assign bus.init_done       = done;

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// tb_regfile_write_ctrl: directed bench for regfile_write_ctrl (NUM_REQ=2).
// A behavioural 32x64 register file captures the rf_* port so stored contents
// can be checked as well as the port itself. Each step() lands 1 time unit
// after a rising edge; inputs are changed there and outputs sampled one unit
// later, so "cycle n" below is the interval after that edge.
module tb_regfile_write_ctrl;

    localparam int NUM_REQ = 2;
    localparam int AW      = 5;
    localparam int DW      = 64;

    localparam logic [63:0] D_LOAD = 64'h1234567890ABCDEF;
    localparam logic [63:0] D_R1   = 64'hCAFEF00DDEADBEEF;
    localparam logic [63:0] D_A    = 64'hAA55AA55AA55AA55;
    localparam logic [63:0] D_B    = 64'h55AA55AA55AA55AA;
    localparam logic [63:0] D_7    = 64'h0707070707070707;

    logic clk;
    logic reset_n;

    regfile_write_ctrl_if #(.NUM_REQ(NUM_REQ), .ADDR_W(AW), .DATA_W(DW)) bus ();

    regfile_write_ctrl #(.NUM_REQ(NUM_REQ)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] mem [32];

    always @(posedge clk) begin
        if (bus.rf_write_enable) begin
            mem[bus.rf_write_addr] <= bus.rf_write_data;
        end
    end

    int vectors;
    int miscompares;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_addr[i*AW +: AW] = a;
        bus.req_data[i*DW +: DW] = d;
    endtask

    // Called while in cycle 0; leaves the bench in cycle 31 after checking the
    // zero-fill writes of addresses 0..30 and that ready/init_done stay low.
    task automatic init_sweep();
        for (int k = 0; k < 31; k++) begin
            step();
            settle();
            chk("init_write", {bus.rf_write_enable, bus.rf_write_addr, bus.rf_write_data},
                {1'b1, AW'(k), {DW{1'b0}}});
            chk("init_ready", bus.req_ready, 2'b00);
            chk("init_done_low", bus.init_done, 1'b0);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < 32; i++) mem[i] = '1;
        reset_n       = 1'b0;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;

        // Reset values
        repeat (3) step();
        settle();
        chk("rst_we", bus.rf_write_enable, 1'b0);
        chk("rst_addr", bus.rf_write_addr, 5'd0);
        chk("rst_data", bus.rf_write_data, 64'd0);
        chk("rst_done", bus.init_done, 1'b0);
        chk("rst_gid", bus.grant_id, 1'b0);
        chk("rst_ready", bus.req_ready, 2'b00);

        // Cycle 0: release reset with requester 0 already waiting
        reset_n       = 1'b1;
        bus.req_valid = 2'b01;
        set_req(0, 5'd5, D_LOAD);
        settle();
        chk("c0_ready", bus.req_ready, 2'b00);
        chk("c0_we", bus.rf_write_enable, 1'b0);
        init_sweep();

        // Cycle 32: last zero-fill write visible, RUN, req0 accepted
        step();
        settle();
        chk("c32_write", {bus.rf_write_enable, bus.rf_write_addr, bus.rf_write_data},
            {1'b1, 5'd31, 64'd0});
        chk("c32_done", bus.init_done, 1'b1);
        chk("c32_ready", bus.req_ready, 2'b01);

        // Cycle 33: req0 write on the port; requester drops, nothing valid
        step();
        bus.req_valid = 2'b00;
        settle();
        chk("c33_write", {bus.rf_write_enable, bus.rf_write_addr, bus.rf_write_data},
            {1'b1, 5'd5, D_LOAD});
        chk("c33_gid", bus.grant_id, 1'b0);
        chk("idle_ready", bus.req_ready, 2'b00);

        // Cycle 34: idle -> enable drops, addr/data hold; memory image check
        step();
        settle();
        chk("idle_write", {bus.rf_write_enable, bus.rf_write_addr, bus.rf_write_data},
            {1'b0, 5'd5, D_LOAD});
        for (int i = 0; i < 32; i++) begin
            chk("mem_after_init", mem[i], (i == 5) ? D_LOAD : 64'd0);
        end

        // Cycles 34..36: requester 1 alone, granted every cycle
        bus.req_valid = 2'b10;
        set_req(1, 5'd9, D_R1);
        settle();
        chk("r1_ready_a", bus.req_ready, 2'b10);
        step();
        settle();
        chk("r1_write_a", {bus.rf_write_enable, bus.rf_write_addr, bus.rf_write_data},
            {1'b1, 5'd9, D_R1});
        chk("r1_gid_a", bus.grant_id, 1'b1);
        chk("r1_ready_b", bus.req_ready, 2'b10);
        step();
        settle();
        chk("r1_gid_b", bus.grant_id, 1'b1);
        chk("r1_ready_c", bus.req_ready, 2'b10);

        // Cycle 37: third req1 write visible, then both requesters contend
        // with rr_ptr back at 0 -> req0 first, then strict alternation.
        step();
        bus.req_valid = 2'b11;
        set_req(0, 5'd2, D_A);
        set_req(1, 5'd3, D_B);
        settle();
        chk("r1_write_c", {bus.rf_write_enable, bus.rf_write_addr, bus.grant_id},
            {1'b1, 5'd9, 1'b1});
        chk("both_ready_0", bus.req_ready, 2'b01);
        step();
        settle();
        chk("both_write_0", {bus.rf_write_enable, bus.rf_write_addr, bus.rf_write_data},
            {1'b1, 5'd2, D_A});
        chk("both_gid_0", bus.grant_id, 1'b0);
        chk("both_ready_1", bus.req_ready, 2'b10);
        step();
        settle();
        chk("both_write_1", {bus.rf_write_enable, bus.rf_write_addr, bus.rf_write_data},
            {1'b1, 5'd3, D_B});
        chk("both_gid_1", bus.grant_id, 1'b1);
        chk("both_ready_2", bus.req_ready, 2'b01);

        // Reset pulse while a write to addr 7 is being accepted
        step();
        bus.req_valid = 2'b01;
        set_req(0, 5'd7, D_7);
        reset_n = 1'b0;
        settle();
        chk("pulse_gid", bus.grant_id, 1'b0);
        chk("pulse_ready", bus.req_ready, 2'b01);
        step();
        settle();
        chk("pulse_we", bus.rf_write_enable, 1'b0);
        chk("pulse_addr", bus.rf_write_addr, 5'd0);
        chk("pulse_data", bus.rf_write_data, 64'd0);
        chk("pulse_done", bus.init_done, 1'b0);
        chk("pulse_ready_off", bus.req_ready, 2'b00);

        // Restart: both requesters held valid through INIT
        reset_n       = 1'b1;
        bus.req_valid = 2'b11;
        set_req(0, 5'd2, D_A);
        set_req(1, 5'd3, D_B);
        settle();
        chk("re_c0_ready", bus.req_ready, 2'b00);
        init_sweep();
        step();
        settle();
        chk("re_c32_done", bus.init_done, 1'b1);
        chk("re_c32_ready", bus.req_ready, 2'b01);
        for (int n = 0; n < 4; n++) begin
            step();
            settle();
            chk("rot_write", {bus.rf_write_enable, bus.rf_write_addr, bus.grant_id},
                {1'b1, (n % 2 == 0) ? 5'd2 : 5'd3, (n % 2 == 0) ? 1'b0 : 1'b1});
            chk("rot_ready", bus.req_ready, (n % 2 == 0) ? 2'b10 : 2'b01);
        end

        bus.req_valid = 2'b00;
        step();
        step();
        settle();
        chk("end_we", bus.rf_write_enable, 1'b0);
        chk("mem7_never_written", mem[7], 64'd0);
        chk("mem5_rezeroed", mem[5], 64'd0);
        chk("mem2", mem[2], D_A);
        chk("mem3", mem[3], D_B);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
